instr_encoder: RTL

- Programs instruction memory from field-level commands. It is the encoding side of the core's instruction decoder.
- It accepts per-instruction field bundles (class, funct3, sub flag, rs1, rs2, rd, imm12) over a valid/ready stream.
- Each bundle is packed into a 32-bit RV32I word (R-type ALU, I-type ALU, load, store).
- Encoded words are written sequentially into instruction memory from a base address through an ack-handshaked write port. Used by the bench/boot loader ahead of the core.

---
 rtl/instr_encoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs RV32I field bundles (R/I/load/store) into 32-bit words and writes them
// sequentially to instruction memory over an ack-handshaked port.
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | accepting bundles, writing encoded words
//   FLUSH | last bundle taken, waiting for final write ack
//   DONE  | program loaded, waiting for next start
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_sub,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [11:0]       in_imm12,
    input  logic              in_last,
    output logic              imem_wEn,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic              ack_eff;
    logic              accept;
    logic              illegal;
    logic [31:0]       enc;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    always_comb begin
        illegal = in_sub && ((in_class != 2'b00) ||
                             ((in_funct3 != 3'b000) && (in_funct3 != 3'b101)));
        case (in_class)
            2'b00:   enc = {(in_sub ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1,
                            in_funct3, in_rd, 7'b0110011};
            2'b01:   enc = {in_imm12, in_rs1, in_funct3, in_rd, 7'b0010011};
            2'b10:   enc = {in_imm12, in_rs1, in_funct3, in_rd, 7'b0000011};
            default: enc = {in_imm12[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm12[4:0], 7'b0100011};
        endcase
    end

    // Ack is only meaningful while a write is actually pending.
    assign ack_eff  = wen_q && imem_ack;
    assign in_ready = (state_q == S_RUN) && (!wen_q || imem_ack);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        count_d = count_q;
        err_d   = err_q;

        if (ack_eff) begin
            wen_d   = 1'b0;
            count_d = count_q + CNT_W'(1);
            addr_d  = addr_q + ADDR_W'(4);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = base_addr & ALIGN_MASK;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wen_d   = 1'b1;
                        wdata_d = enc;
                    end
                    if (in_last) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!wen_q || ack_eff) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_wEn   = wen_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign count      = count_q;

endmodule
